return_stack: RTL and testbench

RETURN_STACK -- requirements
Module: return_stack

---
 rtl/return_stack.sv | 99 +++++++++
 tb/tb_return_stack.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Hardware return-address stack: DEPTH x WIDTH register file with a fill count
// and sticky overflow/underflow flags. Requests take effect on the next rising edge.
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stack_push,
    input  logic                       stack_pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW:0]      count_m1;
    logic [AW-1:0]    top_idx;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign count_m1 = count_q - 1'b1;
    assign top_idx  = count_m1[AW-1:0];

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (stack_push && stack_pop) begin
            // Replace the top in place; on an empty stack this degrades to a plain push.
            wr_en = 1'b1;
            if (is_empty) begin
                count_d = count_q + 1'b1;
            end else begin
                wr_addr = top_idx;
            end
        end else if (stack_push) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + 1'b1;
            end
        end else if (stack_pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_m1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage is intentionally not reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_q[wr_addr] <= push_data;
        end
    end

    assign top             = is_empty ? '0 : entry_q[top_idx];
    assign count           = count_q;
    assign empty           = is_empty;
    assign full            = is_full;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed scenarios followed by random operations,
// checked against a queue-based model of the stack.
module tb_return_stack;

    localparam int WIDTH = 12;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             stack_push;
    logic             stack_pop;
    logic             clear;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             stack_overflow;
    logic             stack_underflow;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] model_q [$];
    logic             m_ovf;
    logic             m_unf;

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .stack_push      (stack_push),
        .stack_pop       (stack_pop),
        .clear           (clear),
        .push_data       (push_data),
        .top             (top),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, expressed on a queue.
    task automatic model_step(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] d);
        if (c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && o) begin
            if (model_q.size() > 0) model_q[model_q.size()-1] = d;
            else model_q.push_back(d);
        end else if (p) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(d);
        end else if (o) begin
            if (model_q.size() == 0) m_unf = 1'b1;
            else void'(model_q.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_top;
        exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".top"},   32'(top),   32'(exp_top));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(stack_overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(stack_underflow), 32'(m_unf));
    endtask

    task automatic op(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] d);
        @(negedge clk);
        stack_push = p;
        stack_pop  = o;
        clear      = c;
        push_data  = d;
        @(posedge clk);
        #1;
        model_step(p, o, c, d);
    endtask

    task automatic idle();
        @(negedge clk);
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        clear      = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        rst         = 1'b1;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        clear       = 1'b0;
        push_data   = '0;

        // Power-on reset
        #1 rst = 1'b0;
        #12;
        check_all("por");
        @(negedge clk);
        rst = 1'b1;

        // Basic push/pop
        op(1, 0, 0, 12'h00A);
        op(1, 0, 0, 12'h00B);
        op(1, 0, 0, 12'h00C);
        check(">3push.count", 32'(count), 32'd3);
        check(">3push.top",   32'(top),   32'h00C);
        op(0, 1, 0, 12'h0);
        op(0, 1, 0, 12'h0);
        check("2pop.count", 32'(count), 32'd1);
        check("2pop.top",   32'(top),   32'h00A);
        check_all("basic");

        // Fill to full and overflow
        do_reset();
        for (int i = 0; i < 8; i++) op(1, 0, 0, 12'(12'h100 + i));
        check("fill.full", 32'(full), 32'd1);
        check("fill.top",  32'(top),  32'h107);
        op(1, 0, 0, 12'h1FF);
        check("ovf.count", 32'(count), 32'd8);
        check("ovf.top",   32'(top),   32'h107);
        check("ovf.flag",  32'(stack_overflow), 32'd1);
        check_all("overflow");
        op(1, 1, 0, 12'h2AB);
        check_all("full_replace");

        // Underflow then push
        do_reset();
        op(0, 1, 0, 12'h0);
        check("unf.flag",  32'(stack_underflow), 32'd1);
        check("unf.count", 32'(count), 32'd0);
        check("unf.empty", 32'(empty), 32'd1);
        op(1, 0, 0, 12'h055);
        check("unf_push.top",  32'(top), 32'h055);
        check("unf_push.flag", 32'(stack_underflow), 32'd1);
        check_all("underflow");

        // Simultaneous push and pop
        do_reset();
        op(1, 0, 0, 12'h010);
        op(1, 0, 0, 12'h015);
        op(1, 0, 0, 12'h020);
        op(1, 1, 0, 12'h0AA);
        check("swap.count", 32'(count), 32'd3);
        check("swap.top",   32'(top),   32'h0AA);
        check_all("swap");
        do_reset();
        op(1, 1, 0, 12'h011);
        check("swap_empty.top", 32'(top), 32'h011);
        check_all("swap_empty");

        // Clear beats push
        do_reset();
        op(0, 1, 0, 12'h0);
        for (int i = 0; i < 8; i++) op(1, 0, 0, 12'(12'h300 + i));
        op(1, 0, 0, 12'h3FF);
        op(0, 1, 0, 12'h0);
        op(0, 1, 0, 12'h0);
        op(0, 1, 0, 12'h0);
        check_all("pre_clear");
        op(1, 0, 1, 12'h123);
        check("clear.count", 32'(count), 32'd0);
        check_all("clear");

        // Asynchronous reset mid-sequence
        for (int i = 0; i < 4; i++) op(1, 0, 0, 12'(12'h040 + i));
        check_all("pre_async");
        do_reset();
        op(1, 0, 0, 12'h033);
        check("post_async.count", 32'(count), 32'd1);
        check_all("post_async");

        // Random operations
        for (int n = 0; n < 600; n++) begin
            logic p, o, c;
            int   r;
            r = $urandom_range(0, 99);
            c = (r < 3);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            op(p, o, c, 12'($urandom));
            check_all("rand");
            if (n == 300) do_reset();
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
